// File: rtl/color_binarize.sv
// ---------------------------------------------------------------------------
// color_binarize
//   Converts an RGB565 pixel stream to a one-bit skin/colour mask by
//   thresholding the Cb/Cr chroma components against an inclusive window.
//   Also counts matched pixels per frame.
//
//   The pipeline is three registers deep:
//     S1 expands the 5/6-bit components and forms the six chroma products.
//     S2 sums the products.
//     S3 shifts, clamps and compares.
//   All sync, valid and pixel signals travel through the same three
//   registers.
//
// Ports
//   clk           pixel clock
//   rst_n         asynchronous active-low reset
//   pre_hs        line sync in
//   pre_vs        frame sync in, active high
//   pre_clken     pixel valid in
//   pre_imgdata   RGB565 pixel in
//   cb_min/max    Cb window bounds, inclusive; latched at frame start
//   cr_min/max    Cr window bounds, inclusive; latched at frame start
//   post_hs       pre_hs delayed by 3 cycles
//   post_vs       pre_vs delayed by 3 cycles
//   post_clken    pre_clken delayed by 3 cycles
//   post_imgbit   match flag, aligned with post_clken
//   post_imgdata  pre_imgdata delayed by 3 cycles
//   match_cnt     matched-pixel count of the last completed frame
//   frame_done    one-cycle pulse when match_cnt updates
// ---------------------------------------------------------------------------
module color_binarize (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pre_hs,
    input  logic        pre_vs,
    input  logic        pre_clken,
    input  logic [15:0] pre_imgdata,
    input  logic [7:0]  cb_min,
    input  logic [7:0]  cb_max,
    input  logic [7:0]  cr_min,
    input  logic [7:0]  cr_max,
    output logic        post_hs,
    output logic        post_vs,
    output logic        post_clken,
    output logic        post_imgbit,
    output logic [15:0] post_imgdata,
    output logic [19:0] match_cnt,
    output logic        frame_done
);

    localparam int PROD_W = 18;

    // Clamp a shifted chroma value into the 8-bit range.
    function automatic logic [7:0] clamp8(input logic signed [PROD_W-1:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    // Saturating increment for the 20-bit match counter.
    function automatic logic [19:0] sat_inc(input logic [19:0] a, input logic inc);
        if (inc && (a != 20'hFFFFF))
            return a + 20'd1;
        else
            return a;
    endfunction

    // Shadow window, reloaded from the *_min/*_max inputs at frame start
    logic       pre_vs_d;
    logic       vs_rise;
    logic [7:0] cb_lo, cb_hi, cr_lo, cr_hi;

    assign vs_rise = pre_vs & ~pre_vs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_vs_d <= 1'b0;
            cb_lo    <= 8'h00;
            cb_hi    <= 8'hFF;
            cr_lo    <= 8'h00;
            cr_hi    <= 8'hFF;
        end else begin
            pre_vs_d <= pre_vs;
            if (vs_rise) begin
                cb_lo <= cb_min;
                cb_hi <= cb_max;
                cr_lo <= cr_min;
                cr_hi <= cr_max;
            end
        end
    end

    // Bit-replicating expansion to 8 bits, then zero-extension into the
    // signed product width.
    logic [7:0]                r8, g8, b8;
    logic signed [PROD_W-1:0]  r_s, g_s, b_s;

    always_comb begin
        r8  = {pre_imgdata[15:11], pre_imgdata[15:13]};
        g8  = {pre_imgdata[10:5],  pre_imgdata[10:9]};
        b8  = {pre_imgdata[4:0],   pre_imgdata[4:2]};
        r_s = signed'({{(PROD_W-8){1'b0}}, r8});
        g_s = signed'({{(PROD_W-8){1'b0}}, g8});
        b_s = signed'({{(PROD_W-8){1'b0}}, b8});
    end

    // ---- S1: expand and multiply ----
    // The window is carried with each pixel so that a shadow reload never
    // affects pixels already in flight.
    logic signed [PROD_W-1:0] cb_r_p0, cb_g_p0, cb_b_p0;
    logic signed [PROD_W-1:0] cr_r_p0, cr_g_p0, cr_b_p0;
    logic [7:0]               cb_lo_p0, cb_hi_p0, cr_lo_p0, cr_hi_p0;
    logic                     hs_p0, vs_p0, clken_p0;
    logic [15:0]              data_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cb_r_p0  <= '0;
            cb_g_p0  <= '0;
            cb_b_p0  <= '0;
            cr_r_p0  <= '0;
            cr_g_p0  <= '0;
            cr_b_p0  <= '0;
            cb_lo_p0 <= '0;
            cb_hi_p0 <= '0;
            cr_lo_p0 <= '0;
            cr_hi_p0 <= '0;
            hs_p0    <= 1'b0;
            vs_p0    <= 1'b0;
            clken_p0 <= 1'b0;
            data_p0  <= '0;
        end else begin
            cb_r_p0  <= r_s * -18'sd43;
            cb_g_p0  <= g_s * -18'sd85;
            cb_b_p0  <= b_s *  18'sd128;
            cr_r_p0  <= r_s *  18'sd128;
            cr_g_p0  <= g_s * -18'sd107;
            cr_b_p0  <= b_s * -18'sd21;
            cb_lo_p0 <= cb_lo;
            cb_hi_p0 <= cb_hi;
            cr_lo_p0 <= cr_lo;
            cr_hi_p0 <= cr_hi;
            hs_p0    <= pre_hs;
            vs_p0    <= pre_vs;
            clken_p0 <= pre_clken;
            data_p0  <= pre_imgdata;
        end
    end

    // ---- S2: sum the products ----
    logic signed [PROD_W-1:0] cb_sum_p1, cr_sum_p1;
    logic [7:0]               cb_lo_p1, cb_hi_p1, cr_lo_p1, cr_hi_p1;
    logic                     hs_p1, vs_p1, clken_p1;
    logic [15:0]              data_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cb_sum_p1 <= '0;
            cr_sum_p1 <= '0;
            cb_lo_p1  <= '0;
            cb_hi_p1  <= '0;
            cr_lo_p1  <= '0;
            cr_hi_p1  <= '0;
            hs_p1     <= 1'b0;
            vs_p1     <= 1'b0;
            clken_p1  <= 1'b0;
            data_p1   <= '0;
        end else begin
            cb_sum_p1 <= cb_r_p0 + cb_g_p0 + cb_b_p0;
            cr_sum_p1 <= cr_r_p0 + cr_g_p0 + cr_b_p0;
            cb_lo_p1  <= cb_lo_p0;
            cb_hi_p1  <= cb_hi_p0;
            cr_lo_p1  <= cr_lo_p0;
            cr_hi_p1  <= cr_hi_p0;
            hs_p1     <= hs_p0;
            vs_p1     <= vs_p0;
            clken_p1  <= clken_p0;
            data_p1   <= data_p0;
        end
    end

    // ---- S3: shift, clamp and compare ----
    // An inverted window (lo > hi) simply never satisfies both bounds.
    logic signed [PROD_W-1:0] cb_off, cr_off;
    logic [7:0]               cb_val, cr_val;
    logic                     match;

    always_comb begin
        cb_off = (cb_sum_p1 >>> 8) + 18'sd128;
        cr_off = (cr_sum_p1 >>> 8) + 18'sd128;
        cb_val = clamp8(cb_off);
        cr_val = clamp8(cr_off);
        match  = clken_p1 &&
                 (cb_val >= cb_lo_p1) && (cb_val <= cb_hi_p1) &&
                 (cr_val >= cr_lo_p1) && (cr_val <= cr_hi_p1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_hs      <= 1'b0;
            post_vs      <= 1'b0;
            post_clken   <= 1'b0;
            post_imgbit  <= 1'b0;
            post_imgdata <= '0;
        end else begin
            post_hs      <= hs_p1;
            post_vs      <= vs_p1;
            post_clken   <= clken_p1;
            post_imgbit  <= match;
            post_imgdata <= data_p1;
        end
    end

    // ---- Frame statistics ----
    // A match on the same cycle as the post_vs edge belongs to the
    // closing frame, so it is folded into the reported count.
    logic        post_vs_d;
    logic        post_vs_rise;
    logic [19:0] acc;

    assign post_vs_rise = post_vs & ~post_vs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_vs_d  <= 1'b0;
            acc        <= '0;
            match_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            post_vs_d  <= post_vs;
            frame_done <= post_vs_rise;
            if (post_vs_rise) begin
                match_cnt <= sat_inc(acc, post_imgbit);
                acc       <= '0;
            end else begin
                acc <= sat_inc(acc, post_imgbit);
            end
        end
    end

endmodule

// File: tb/tb_color_binarize.sv
// ---------------------------------------------------------------------------
// tb_color_binarize
//   Directed testbench for color_binarize. Inputs are driven 1 time unit
//   after the rising clock edge and outputs are checked at the same point,
//   away from the active edge.
// ---------------------------------------------------------------------------
module tb_color_binarize;

    localparam logic [15:0] RED   = 16'hF800;  // Cb=85,  Cr=255
    localparam logic [15:0] GREEN = 16'h07E0;  // Cb=43,  Cr=21
    localparam logic [15:0] WHITE = 16'hFFFF;  // Cb=128, Cr=128
    localparam logic [15:0] BLACK = 16'h0000;  // Cb=128, Cr=128

    logic        clk;
    logic        rst_n;
    logic        pre_hs, pre_vs, pre_clken;
    logic [15:0] pre_imgdata;
    logic [7:0]  cb_min, cb_max, cr_min, cr_max;
    logic        post_hs, post_vs, post_clken, post_imgbit;
    logic [15:0] post_imgdata;
    logic [19:0] match_cnt;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    color_binarize dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pre_hs       (pre_hs),
        .pre_vs       (pre_vs),
        .pre_clken    (pre_clken),
        .pre_imgdata  (pre_imgdata),
        .cb_min       (cb_min),
        .cb_max       (cb_max),
        .cr_min       (cr_min),
        .cr_max       (cr_max),
        .post_hs      (post_hs),
        .post_vs      (post_vs),
        .post_clken   (post_clken),
        .post_imgbit  (post_imgbit),
        .post_imgdata (post_imgdata),
        .match_cnt    (match_cnt),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one input cycle and advance past the edge that samples it.
    task automatic step(input logic hs, input logic vs, input logic ce, input logic [15:0] d);
        pre_hs      = hs;
        pre_vs      = vs;
        pre_clken   = ce;
        pre_imgdata = d;
        @(posedge clk);
        #1;
    endtask

    // Raise pre_vs and check the frame_done pulse four cycles later.
    task automatic vs_edge(input string tag, input int exp_cnt);
        step(0, 1, 0, BLACK);
        step(0, 1, 0, BLACK);
        step(0, 1, 0, BLACK);
        check({tag, "_post_vs"}, post_vs, 1);
        check({tag, "_fd_early"}, frame_done, 0);
        step(0, 0, 0, BLACK);
        check({tag, "_fd"}, frame_done, 1);
        check({tag, "_cnt"}, match_cnt, exp_cnt);
        step(0, 0, 0, BLACK);
        check({tag, "_fd_once"}, frame_done, 0);
    endtask

    task automatic set_window(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        cb_min = a;
        cb_max = b;
        cr_min = c;
        cr_max = d;
    endtask

    initial begin
        rst_n = 1'b0;
        pre_hs = 0; pre_vs = 0; pre_clken = 0; pre_imgdata = '0;
        set_window(8'd0, 8'd0, 8'd0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_post_clken", post_clken, 0);
        check("rst_imgbit", post_imgbit, 0);
        check("rst_match_cnt", match_cnt, 0);
        check("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;

        // Default window: every valid pixel matches before the first frame edge.
        step(0, 0, 1, BLACK);
        step(0, 0, 0, BLACK);
        step(0, 0, 0, BLACK);
        check("dflt_imgbit", post_imgbit, 1);
        set_window(8'd80, 8'd90, 8'd250, 8'd255);
        vs_edge("f0", 1);

        // Red pixel: match appears exactly three cycles after sampling.
        step(0, 0, 1, RED);
        step(0, 0, 0, BLACK);
        check("red_lat2", post_imgbit, 0);
        step(0, 0, 0, BLACK);
        check("red_imgbit", post_imgbit, 1);
        check("red_data", post_imgdata, RED);
        check("red_clken", post_clken, 1);

        // White and black: neutral chroma, outside the window.
        step(1, 0, 1, WHITE);
        step(0, 0, 1, BLACK);
        step(1, 0, 0, BLACK);
        check("white_imgbit", post_imgbit, 0);
        check("white_data", post_imgdata, WHITE);
        check("white_hs", post_hs, 1);
        check("white_clken", post_clken, 1);
        step(0, 0, 0, BLACK);
        check("black_imgbit", post_imgbit, 0);
        check("black_hs", post_hs, 0);
        check("black_clken", post_clken, 1);
        step(0, 0, 0, BLACK);
        check("bubble_hs", post_hs, 1);
        check("bubble_clken", post_clken, 0);
        vs_edge("f1", 1);

        // Frame with 1000 reds among 2000 valid pixels.
        for (int i = 0; i < 2000; i++)
            step((i % 100) < 80, 0, 1, (i % 2 == 0) ? RED : GREEN);
        vs_edge("f1000", 1000);

        // Frame with no reds.
        for (int i = 0; i < 500; i++)
            step(1, 0, 1, (i % 2 == 0) ? GREEN : WHITE);
        vs_edge("fzero", 0);

        // Mid-frame window change takes effect only at the next frame.
        for (int i = 0; i < 10; i++) step(1, 0, 1, RED);
        cb_min = 8'd200;
        for (int i = 0; i < 10; i++) step(1, 0, 1, RED);
        vs_edge("fmid", 20);
        for (int i = 0; i < 10; i++) step(1, 0, 1, RED);
        step(0, 0, 0, BLACK);
        step(0, 0, 0, BLACK);
        check("mid_after_imgbit", post_imgbit, 0);

        // Inverted window: nothing matches.
        set_window(8'd100, 8'd50, 8'd250, 8'd255);
        vs_edge("fprev", 0);
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0: step(0, 0, 1, RED);
                1: step(0, 0, 1, BLACK);
                2: step(0, 0, 1, WHITE);
                default: step(0, 0, 1, GREEN);
            endcase
            if (i >= 3) check("inv_imgbit", post_imgbit, 0);
        end
        set_window(8'd80, 8'd90, 8'd250, 8'd255);
        vs_edge("finv", 0);

        // Reset during active pixels.
        for (int i = 0; i < 5; i++) step(1, 0, 1, RED);
        check("pre_rst_imgbit", post_imgbit, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_hs", post_hs, 0);
        check("mrst_clken", post_clken, 0);
        check("mrst_imgbit", post_imgbit, 0);
        check("mrst_data", post_imgdata, 0);
        check("mrst_cnt", match_cnt, 0);
        check("mrst_fd", frame_done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) step(1, 0, 1, BLACK);
        check("post_rst_dflt", post_imgbit, 1);
        vs_edge("frst", 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
